// File: rtl/tpg_pattern_player_pkg.sv
// Shared types and constants for the pattern player.
// PI/PO widths are fixed by the alu CUT; depth, settle and counter widths are top parameters.
package tpg_pkg;

  localparam int NINPUTS    = 5;
  localparam int NOUTPUTS   = 2;
  localparam int NPAT_DEF   = 16;
  localparam int SETTLE_DEF = 2;
  localparam int CNTW_DEF   = 8;
  localparam int POPW       = $clog2(NINPUTS + 1);

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    STROBE,
    DONE
  } state_e;

  typedef struct packed {
    logic [NINPUTS-1:0]  pi;
    logic [NOUTPUTS-1:0] xpct;
    logic [NOUTPUTS-1:0] mask;
  } pat_entry_t;

  function automatic logic [POPW-1:0] popcount(input logic [NINPUTS-1:0] v);
    logic [POPW-1:0] c;
    c = '0;
    for (int i = 0; i < NINPUTS; i++) c = c + POPW'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/tpg_pattern_player_if.sv
// Host-side bus of the pattern player: pattern load port, run control and run results.
interface tpg_pattern_player_if
  import tpg_pkg::*;
#(
  parameter int NPAT = NPAT_DEF,
  parameter int CNTW = CNTW_DEF
) ();

  localparam int AW = $clog2(NPAT);

  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [NINPUTS-1:0]  wr_pi;
  logic [NOUTPUTS-1:0] wr_xpct;
  logic [NOUTPUTS-1:0] wr_mask;
  logic                start;
  logic [AW:0]         num_pat;
  logic                busy;
  logic                done;
  logic [CNTW-1:0]     fail_cnt;
  logic [AW-1:0]       first_fail;
  logic                fail_seen;

  modport master (
    output wr_en, wr_addr, wr_pi, wr_xpct, wr_mask, start, num_pat,
    input  busy, done, fail_cnt, first_fail, fail_seen
  );

  modport slave (
    input  wr_en, wr_addr, wr_pi, wr_xpct, wr_mask, start, num_pat,
    output busy, done, fail_cnt, first_fail, fail_seen
  );

endinterface

// File: rtl/tpg_pattern_player_mem.sv
// Pattern store: NPAT entries, synchronous write, asynchronous read. Contents are not reset.
module tpg_pattern_mem
  import tpg_pkg::*;
#(
  parameter int NPAT = NPAT_DEF
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [$clog2(NPAT)-1:0] wr_addr,
  input  pat_entry_t              wr_data,
  input  logic [$clog2(NPAT)-1:0] rd_addr,
  output pat_entry_t              rd_data
);

  pat_entry_t mem_q [NPAT];
  pat_entry_t mem_d [NPAT];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/tpg_pattern_player.sv
// Non-scan pattern applier: drives stored PI vectors into the CUT, strobes masked POs, counts fails.
// Optional PI toggle counter enabled by defining TPG_TOGGLE_CNT_EN.
//
//   state  | meaning
//   IDLE   | waiting for start; pattern writes accepted
//   APPLY  | drive mem[idx].pi onto pi_out, load settle timer
//   WAIT   | settle timer counting down to terminal count
//   STROBE | compare po_in with expected under mask, advance idx
//   DONE   | one-cycle done pulse, results frozen
module tpg_pattern_player
  import tpg_pkg::*;
#(
  parameter int NPAT   = NPAT_DEF,
  parameter int SETTLE = SETTLE_DEF,
  parameter int CNTW   = CNTW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  tpg_pattern_player_if.slave bus,
  output logic [NINPUTS-1:0]  pi_out,
  input  logic [NOUTPUTS-1:0] po_in
`ifdef TPG_TOGGLE_CNT_EN
  ,
  output logic [CNTW-1:0]     toggle_cnt
`endif
);

  localparam int AW = $clog2(NPAT);
  localparam int NW = AW + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [NW-1:0]       n_q, n_d;
  logic [SW-1:0]       cnt_q, cnt_d;
  logic [NINPUTS-1:0]  pi_out_q, pi_out_d;
  logic [CNTW-1:0]     fail_cnt_q, fail_cnt_d;
  logic [AW-1:0]       first_fail_q, first_fail_d;
  logic                fail_seen_q, fail_seen_d;
  logic [NOUTPUTS-1:0] miss;
  logic                last;
  pat_entry_t          wr_entry, rd_entry;

  assign wr_entry = '{pi: bus.wr_pi, xpct: bus.wr_xpct, mask: bus.wr_mask};

  tpg_pattern_mem #(.NPAT(NPAT)) u_mem (
    .clk     (clk),
    .wr_en   (bus.wr_en && (state_q == IDLE)),
    .wr_addr (bus.wr_addr),
    .wr_data (wr_entry),
    .rd_addr (idx_q),
    .rd_data (rd_entry)
  );

  assign miss = (po_in ^ rd_entry.xpct) & rd_entry.mask;
  assign last = ({1'b0, idx_q} == (n_q - NW'(1)));

`ifdef TPG_TOGGLE_CNT_EN
  logic [CNTW-1:0] toggle_cnt_q, toggle_cnt_d;
  logic [CNTW:0]   toggle_sum;

  assign toggle_sum = {1'b0, toggle_cnt_q} + (CNTW+1)'(popcount(rd_entry.pi ^ pi_out_q));
  assign toggle_cnt = toggle_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      n_q          <= '0;
      cnt_q        <= '0;
      pi_out_q     <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
`ifdef TPG_TOGGLE_CNT_EN
      toggle_cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      pi_out_q     <= pi_out_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      fail_seen_q  <= fail_seen_d;
`ifdef TPG_TOGGLE_CNT_EN
      toggle_cnt_q <= toggle_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.num_pat == '0) ? DONE : APPLY;
      APPLY:   state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = STROBE;
      STROBE:  state_d = last ? DONE : APPLY;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == APPLY) || (state_q == WAIT) || (state_q == STROBE);
    bus.done = (state_q == DONE);
  end

  always_comb begin
    idx_d        = idx_q;
    n_d          = n_q;
    cnt_d        = cnt_q;
    pi_out_d     = pi_out_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    fail_seen_d  = fail_seen_q;
`ifdef TPG_TOGGLE_CNT_EN
    toggle_cnt_d = toggle_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          idx_d        = '0;
          fail_cnt_d   = '0;
          first_fail_d = '0;
          fail_seen_d  = 1'b0;
          n_d          = (bus.num_pat > NW'(NPAT)) ? NW'(NPAT) : bus.num_pat;
`ifdef TPG_TOGGLE_CNT_EN
          toggle_cnt_d = '0;
`endif
        end
      end
      APPLY: begin
        pi_out_d = rd_entry.pi;
        cnt_d    = SW'(SETTLE - 1);
`ifdef TPG_TOGGLE_CNT_EN
        toggle_cnt_d = toggle_sum[CNTW] ? '1 : toggle_sum[CNTW-1:0];
`endif
      end
      WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - SW'(1);
      end
      STROBE: begin
        if (miss != '0) begin
          if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNTW'(1);
          if (!fail_seen_q) begin
            first_fail_d = idx_q;
            fail_seen_d  = 1'b1;
          end
        end
        if (!last) idx_d = idx_q + AW'(1);
      end
      default: ;
    endcase
  end

  assign pi_out         = pi_out_q;
  assign bus.fail_cnt   = fail_cnt_q;
  assign bus.first_fail = first_fail_q;
  assign bus.fail_seen  = fail_seen_q;

endmodule

// File: tb/tb_tpg_pattern_player.sv
// Self-checking bench for tpg_pattern_player with an alu CUT model and a per-run result scoreboard.
module tb_tpg_pattern_player;
  import tpg_pkg::*;

  localparam int NPAT   = 16;
  localparam int SETTLE = 2;
  localparam int CNTW   = 8;
  localparam int AW     = 4;
  localparam int NW     = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] pi_out;
  logic [1:0] po_in;
  int         fault_mode = 0;
`ifdef TPG_TOGGLE_CNT_EN
  logic [CNTW-1:0] toggle_cnt;
`endif

  always #5 clk = ~clk;

  tpg_pattern_player_if #(.NPAT(NPAT), .CNTW(CNTW)) bus ();

  tpg_pattern_player #(.NPAT(NPAT), .SETTLE(SETTLE), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .pi_out     (pi_out),
    .po_in      (po_in)
`ifdef TPG_TOGGLE_CNT_EN
    ,
    .toggle_cnt (toggle_cnt)
`endif
  );

  typedef struct {
    int         fcnt;
    bit         fseen;
    int         ffirst;
    int         cycles;
    int         busy_cycles;
    logic [4:0] last_pi;
    int         tog;
  } exp_t;

  exp_t       sb[$];
  logic [4:0] sh_pi   [NPAT];
  logic [1:0] sh_xpct [NPAT];
  logic [1:0] sh_mask [NPAT];
  logic [4:0] model_prev_pi = '0;
  int         checks = 0;
  int         errors = 0;

  // Pattern-file order puts the leftmost character at vector bit 0.
  function automatic logic [4:0] rev5(input logic [4:0] f);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = f[4-i];
    return r;
  endfunction

  function automatic logic [1:0] rev2(input logic [1:0] f);
    return {f[0], f[1]};
  endfunction

  // alu: bit0=ain[1] bit1=ain[0] bit2=bin[1] bit3=bin[0] bit4=sel; sel ? a&b : a|b; po bit0=zout[1]
  function automatic logic [1:0] cut(input logic [4:0] pi, input int mode);
    logic [1:0] a, b, z, po;
    a  = {pi[0], pi[1]};
    b  = {pi[2], pi[3]};
    z  = pi[4] ? (a & b) : (a | b);
    po = {z[0], z[1]};
    if (mode == 1) po[0] = 1'b0;
    if (mode == 2) po[0] = ~po[0];
    return po;
  endfunction

  always_comb po_in = cut(pi_out, fault_mode);

  task automatic write_raw(input int addr, input logic [4:0] pi, input logic [1:0] x, input logic [1:0] m);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr[AW-1:0];
    bus.wr_pi   = pi;
    bus.wr_xpct = x;
    bus.wr_mask = m;
    @(negedge clk);
    bus.wr_en = 1'b0;
    sh_pi[addr]   = pi;
    sh_xpct[addr] = x;
    sh_mask[addr] = m;
  endtask

  task automatic write_file(input int addr, input logic [4:0] pi_f, input logic [1:0] x_f, input logic [1:0] m_f);
    write_raw(addr, rev5(pi_f), rev2(x_f), rev2(m_f));
  endtask

  task automatic push_model(input int num);
    exp_t       e;
    int         n;
    logic [4:0] prev;
    logic [1:0] miss;
    n = (num > NPAT) ? NPAT : num;
    e.fcnt = 0; e.fseen = 1'b0; e.ffirst = 0; e.tog = 0;
    prev = model_prev_pi;
    for (int i = 0; i < n; i++) begin
      e.tog = e.tog + $countones(sh_pi[i] ^ prev);
      if (e.tog > 255) e.tog = 255;
      prev = sh_pi[i];
      miss = (cut(sh_pi[i], fault_mode) ^ sh_xpct[i]) & sh_mask[i];
      if (miss != 2'b00) begin
        if (e.fcnt < 255) e.fcnt++;
        if (!e.fseen) begin e.fseen = 1'b1; e.ffirst = i; end
      end
    end
    e.cycles      = n * (SETTLE + 2) + 1;
    e.busy_cycles = n * (SETTLE + 2);
    e.last_pi     = prev;
    model_prev_pi = prev;
    sb.push_back(e);
  endtask

  task automatic run(input int num, input string name, input bit inject);
    exp_t e;
    int   k, busy_cnt;
    bit   got;
    push_model(num);
    @(negedge clk);
    bus.num_pat = num[NW-1:0];
    bus.start   = 1'b1;
    k = 0; busy_cnt = 0; got = 1'b0;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (inject && k == 5) begin
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = '0;
        bus.wr_pi   = ~sh_pi[0];
        bus.wr_xpct = ~cut(sh_pi[0], 0);
        bus.wr_mask = 2'b11;
      end else begin
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) begin got = 1'b1; break; end
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    e = sb.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s done_timeout: got no done in %0d cycles, want %0d", name, k, e.cycles);
    end
    checks++;
    if (k !== e.cycles) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, k, e.cycles); end
    checks++;
    if (busy_cnt !== e.busy_cycles) begin errors++; $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cnt, e.busy_cycles); end
    checks++;
    if (bus.fail_cnt !== CNTW'(e.fcnt)) begin errors++; $display("FAIL %s fail_cnt: got %0d want %0d", name, bus.fail_cnt, e.fcnt); end
    checks++;
    if (bus.fail_seen !== e.fseen) begin errors++; $display("FAIL %s fail_seen: got %0b want %0b", name, bus.fail_seen, e.fseen); end
    checks++;
    if (bus.first_fail !== AW'(e.ffirst)) begin errors++; $display("FAIL %s first_fail: got %0d want %0d", name, bus.first_fail, e.ffirst); end
    checks++;
    if (pi_out !== e.last_pi) begin errors++; $display("FAIL %s pi_out_hold: got %b want %b", name, pi_out, e.last_pi); end
`ifdef TPG_TOGGLE_CNT_EN
    checks++;
    if (toggle_cnt !== CNTW'(e.tog)) begin errors++; $display("FAIL %s toggle_cnt: got %0d want %0d", name, toggle_cnt, e.tog); end
`endif
    @(negedge clk);
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin errors++; $display("FAIL %s after_done: got done/busy %b want 00", name, {bus.done, bus.busy}); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({pi_out, bus.busy, bus.done, bus.fail_cnt, bus.first_fail, bus.fail_seen} !== '0) begin
      errors++;
      $display("FAIL reset_values: got pi=%b busy=%b done=%b fcnt=%0d ff=%0d fs=%b want all 0",
               pi_out, bus.busy, bus.done, bus.fail_cnt, bus.first_fail, bus.fail_seen);
    end
    rst_n = 1'b1;
  endtask

  task automatic load_pass_set;
    write_file(0, 5'b11101, 2'b10, 2'b11);
    write_file(1, 5'b01101, 2'b00, 2'b11);
    write_file(2, 5'b01111, 2'b01, 2'b11);
  endtask

  task automatic test_pass_run;
    load_pass_set();
    fault_mode = 0;
    run(3, "pass", 1'b0);
  endtask

  task automatic test_stuck_fault;
    fault_mode = 1;
    run(3, "stuck_z1", 1'b0);
    fault_mode = 0;
  endtask

  task automatic test_masked_x;
    write_file(0, 5'b10110, 2'b01, 2'b01);
    fault_mode = 2;
    run(1, "masked_x", 1'b0);
    fault_mode = 0;
  endtask

  task automatic test_zero_pat;
    run(0, "num_pat_0", 1'b0);
  endtask

  task automatic test_busy_ignore;
    load_pass_set();
    run(3, "busy_inject", 1'b1);
    run(3, "after_inject", 1'b0);
  endtask

  task automatic test_overflow;
    logic [4:0] p;
    for (int i = 0; i < NPAT; i++) begin
      p = 5'($urandom);
      write_raw(i, p, ~cut(p, 0), 2'b11);
    end
    run(20, "num_pat_20", 1'b0);
  endtask

  task automatic test_random;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NPAT; i++) write_raw(i, 5'($urandom), 2'($urandom), 2'($urandom));
      fault_mode = int'($urandom_range(0, 2));
      run(int'($urandom_range(1, NPAT)), "random", 1'b0);
    end
    fault_mode = 0;
  endtask

  task automatic test_reset_mid_run;
    load_pass_set();
    fault_mode = 1;
    @(negedge clk);
    bus.num_pat = NW'(3);
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pi_out, bus.busy, bus.done, bus.fail_cnt, bus.first_fail, bus.fail_seen} !== '0) begin
      errors++;
      $display("FAIL mid_run_reset: got pi=%b busy=%b done=%b fcnt=%0d ff=%0d fs=%b want all 0",
               pi_out, bus.busy, bus.done, bus.fail_cnt, bus.first_fail, bus.fail_seen);
    end
`ifdef TPG_TOGGLE_CNT_EN
    checks++;
    if (toggle_cnt !== '0) begin errors++; $display("FAIL mid_run_reset toggle_cnt: got %0d want 0", toggle_cnt); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    fault_mode    = 0;
    model_prev_pi = '0;
    run(3, "rerun_after_reset", 1'b0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_pi   = '0;
    bus.wr_xpct = '0;
    bus.wr_mask = '0;
    bus.start   = 1'b0;
    bus.num_pat = '0;
    test_reset();
    test_pass_run();
    test_stuck_fault();
    test_masked_x();
    test_zero_pat();
    test_busy_ignore();
    test_overflow();
    test_random();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
